// File: rtl/fft_stage_sequencer_if.sv
// Control bundle between the FFT stage sequencer and its surroundings.
// master: the sequencer (drives handshake status and datapath controls).
// slave : the environment (requests transforms, accepts results, reports MAC overflow).
//   start/in_ready       transform request handshake
//   abort                synchronous abandon of the current transform
//   busy, stage_idx      progress status
//   out_valid/out_ready  result handshake, ovf_flag qualifies the result
//   Overflow             MAC array overflow status
//   Local_reset, Wr_En_*, Rd_En_*, MAC_IN_Sel, ROMW_add, Sel_Mapping  datapath controls
interface fft_stage_sequencer_if;
  logic       start;
  logic       in_ready;
  logic       abort;
  logic       busy;
  logic [1:0] stage_idx;
  logic       out_valid;
  logic       out_ready;
  logic       Overflow;
  logic       ovf_flag;
  logic       Local_reset;
  logic       Wr_En_x, Wr_En_A, Wr_En_B, Wr_En_C, Wr_En_D, Wr_En_X;
  logic       Rd_En_x, Rd_En_A, Rd_En_B, Rd_En_C, Rd_En_D, Rd_En_X;
  logic [2:0] MAC_IN_Sel;
  logic [2:0] ROMW_add;
  logic [2:0] Sel_Mapping;

  modport master (
    input  start, abort, out_ready, Overflow,
    output in_ready, busy, stage_idx, out_valid, ovf_flag, Local_reset,
           Wr_En_x, Wr_En_A, Wr_En_B, Wr_En_C, Wr_En_D, Wr_En_X,
           Rd_En_x, Rd_En_A, Rd_En_B, Rd_En_C, Rd_En_D, Rd_En_X,
           MAC_IN_Sel, ROMW_add, Sel_Mapping
  );

  modport slave (
    output start, abort, out_ready, Overflow,
    input  in_ready, busy, stage_idx, out_valid, ovf_flag, Local_reset,
           Wr_En_x, Wr_En_A, Wr_En_B, Wr_En_C, Wr_En_D, Wr_En_X,
           Rd_En_x, Rd_En_A, Rd_En_B, Rd_En_C, Rd_En_D, Rd_En_X,
           MAC_IN_Sel, ROMW_add, Sel_Mapping
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Control FSM for the FFT datapath. One transform per accepted start:
// clear working registers, load x, run NUM_STAGES butterfly passes
// (x->A->B->C->D), copy the last result into X, then present X until taken.
// Data never passes through this block.
//   clk_i  system clock, rising edge
//   rst_i  asynchronous, active-high reset
//   bus    fft_stage_sequencer_if.master (handshakes, status, datapath controls)
//
// state | meaning
// IDLE  | waiting for start, in_ready=1
// CLR   | Local_reset pulse to working registers
// LOAD  | write x from Data_In
// ROMW  | twiddle address for pass k applied, wait ROM_LAT cycles
// EXEC  | pass k: read reg k, write reg k+1
// XFER  | copy reg NUM_STAGES into X through unity W and output mapping
// OUT   | X presented with out_valid until out_ready
module fft_stage_sequencer #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned ROM_LAT    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  fft_stage_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_ROMW, S_EXEC, S_XFER, S_OUT
  } state_t;

  // Enable vectors are indexed by register: 0=x,1=A,2=B,3=C,4=D,5=X
  typedef struct packed {
    logic       in_ready;
    logic       busy;
    logic [1:0] stage_idx;
    logic       out_valid;
    logic       local_reset;
    logic [5:0] wr;
    logic [5:0] rd;
    logic [2:0] mac_sel;
    logic [2:0] romw_add;
    logic [2:0] sel_map;
  } ctrl_t;

  localparam logic [1:0] LAST_K    = 2'(NUM_STAGES - 1);
  localparam logic [2:0] LAST_SRC  = 3'(NUM_STAGES);
  localparam logic [1:0] WAIT_INIT = 2'(ROM_LAT - 1);

  state_t     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [1:0] wait_q, wait_d;
  logic       ovf_q;
  ctrl_t      ctrl_q;
  logic       accept;

  function automatic ctrl_t decode(input state_t s, input logic [1:0] k);
    ctrl_t c;
    c          = '0;
    c.in_ready = (s == S_IDLE);
    c.busy     = (s != S_IDLE);
    case (s)
      S_CLR:  c.local_reset = 1'b1;
      S_LOAD: c.wr = 6'b000001;
      S_ROMW, S_EXEC: begin
        c.stage_idx = k;
        c.rd        = 6'b000001 << k;
        c.mac_sel   = {1'b0, k};
        c.romw_add  = {1'b0, k};
        c.sel_map   = {1'b0, k};
        if (s == S_EXEC) c.wr = 6'b000010 << k;
      end
      S_XFER: begin
        c.rd       = 6'b000001 << LAST_SRC;
        c.mac_sel  = LAST_SRC;
        c.romw_add = 3'd4;   // unity twiddle
        c.sel_map  = 3'd7;   // output ordering
        c.wr       = 6'b100000;
      end
      S_OUT: begin
        c.out_valid = 1'b1;
        c.rd        = 6'b100000;
      end
      default: ;
    endcase
    return c;
  endfunction

  assign accept = (state_q == S_IDLE) && bus.start && !bus.abort;

  // Next state and counters; k and the wait counter are loaded on entry.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wait_d  = wait_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      k_d     = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) state_d = S_CLR;
        S_CLR:  state_d = S_LOAD;
        S_LOAD: begin
          state_d = S_ROMW;
          k_d     = '0;
          wait_d  = WAIT_INIT;
        end
        S_ROMW: begin
          if (wait_q == '0) state_d = S_EXEC;
          else              wait_d  = wait_q - 2'd1;
        end
        S_EXEC: begin
          if (k_q == LAST_K) begin
            state_d = S_XFER;
            k_d     = '0;
          end else begin
            state_d = S_ROMW;
            k_d     = k_q + 2'd1;
            wait_d  = WAIT_INIT;
          end
        end
        S_XFER: state_d = S_OUT;
        S_OUT:  if (bus.out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      wait_q  <= '0;
      ovf_q   <= 1'b0;
      ctrl_q  <= decode(S_IDLE, 2'd0);
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      ctrl_q  <= decode(state_d, k_d);
      if (accept)
        ovf_q <= 1'b0;
      else if (!bus.abort && bus.Overflow &&
               ((state_q == S_EXEC) || (state_q == S_XFER)))
        ovf_q <= 1'b1;
    end
  end

  assign bus.in_ready    = ctrl_q.in_ready;
  assign bus.busy        = ctrl_q.busy;
  assign bus.stage_idx   = ctrl_q.stage_idx;
  assign bus.out_valid   = ctrl_q.out_valid;
  assign bus.ovf_flag    = ovf_q;
  assign bus.Local_reset = ctrl_q.local_reset;
  assign bus.Wr_En_x     = ctrl_q.wr[0];
  assign bus.Wr_En_A     = ctrl_q.wr[1];
  assign bus.Wr_En_B     = ctrl_q.wr[2];
  assign bus.Wr_En_C     = ctrl_q.wr[3];
  assign bus.Wr_En_D     = ctrl_q.wr[4];
  assign bus.Wr_En_X     = ctrl_q.wr[5];
  assign bus.Rd_En_x     = ctrl_q.rd[0];
  assign bus.Rd_En_A     = ctrl_q.rd[1];
  assign bus.Rd_En_B     = ctrl_q.rd[2];
  assign bus.Rd_En_C     = ctrl_q.rd[3];
  assign bus.Rd_En_D     = ctrl_q.rd[4];
  assign bus.Rd_En_X     = ctrl_q.rd[5];
  assign bus.MAC_IN_Sel  = ctrl_q.mac_sel;
  assign bus.ROMW_add    = ctrl_q.romw_add;
  assign bus.Sel_Mapping = ctrl_q.sel_map;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: a default instance (4 stages, ROM_LAT 1)
// and a short instance (2 stages, ROM_LAT 2). Stimulus pushes the expected
// result of each transform; the monitor pops when out_valid rises.
module tb_fft_stage_sequencer;

  typedef struct packed {
    logic [7:0]      lat;   // cycle of first out_valid, CLR cycle = 1
    logic            ovf;
    logic [5:0][7:0] wr;    // first cycle of each Wr_En (X,D,C,B,A,x), 0 = never
    logic [7:0]      hold;  // out_valid cycles
  } exp_t;

  localparam logic [5:0][7:0] WR_DEF = {8'd11, 8'd10, 8'd8, 8'd6, 8'd4, 8'd2};
  localparam logic [5:0][7:0] WR_SH  = {8'd9, 8'd0, 8'd0, 8'd8, 8'd5, 8'd2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b1, ovf_in = 1'b0;
  logic sel = 1'b0;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_stage_sequencer_if if0 ();
  fft_stage_sequencer_if if1 ();

  assign if0.start     = sel ? 1'b0 : start;
  assign if0.abort     = sel ? 1'b0 : abort;
  assign if0.out_ready = sel ? 1'b0 : out_ready;
  assign if0.Overflow  = sel ? 1'b0 : ovf_in;
  assign if1.start     = sel ? start : 1'b0;
  assign if1.abort     = sel ? abort : 1'b0;
  assign if1.out_ready = sel ? out_ready : 1'b0;
  assign if1.Overflow  = sel ? ovf_in : 1'b0;

  fft_stage_sequencer #(.NUM_STAGES(4), .ROM_LAT(1)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  fft_stage_sequencer #(.NUM_STAGES(2), .ROM_LAT(2)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

  logic [5:0] m_wr, m_rd;
  logic       m_ov, m_busy, m_inr, m_lr, m_ovf;
  logic [1:0] m_stage;
  logic [2:0] m_mac, m_romw, m_map;

  always_comb begin
    if (sel) begin
      m_wr = {if1.Wr_En_X, if1.Wr_En_D, if1.Wr_En_C, if1.Wr_En_B, if1.Wr_En_A, if1.Wr_En_x};
      m_rd = {if1.Rd_En_X, if1.Rd_En_D, if1.Rd_En_C, if1.Rd_En_B, if1.Rd_En_A, if1.Rd_En_x};
      m_ov = if1.out_valid; m_busy = if1.busy; m_inr = if1.in_ready; m_lr = if1.Local_reset;
      m_ovf = if1.ovf_flag; m_stage = if1.stage_idx;
      m_mac = if1.MAC_IN_Sel; m_romw = if1.ROMW_add; m_map = if1.Sel_Mapping;
    end else begin
      m_wr = {if0.Wr_En_X, if0.Wr_En_D, if0.Wr_En_C, if0.Wr_En_B, if0.Wr_En_A, if0.Wr_En_x};
      m_rd = {if0.Rd_En_X, if0.Rd_En_D, if0.Rd_En_C, if0.Rd_En_B, if0.Rd_En_A, if0.Rd_En_x};
      m_ov = if0.out_valid; m_busy = if0.busy; m_inr = if0.in_ready; m_lr = if0.Local_reset;
      m_ovf = if0.ovf_flag; m_stage = if0.stage_idx;
      m_mac = if0.MAC_IN_Sel; m_romw = if0.ROMW_add; m_map = if0.Sel_Mapping;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor / scoreboard
  initial begin
    logic            active, prev_ov;
    int              clr_cyc, rel, hold, hold_rd;
    logic [5:0][7:0] first;
    exp_t            cur;
    active = 1'b0; prev_ov = 1'b0; clr_cyc = 0; hold = 0; hold_rd = 0;
    first = '0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0; prev_ov = 1'b0;
        continue;
      end
      chk("wr_exclusive", {31'd0, ($countones(m_wr) > 1) || (m_wr != 6'd0 && m_lr)}, 32'd0);
      chk("in_ready_vs_busy", {31'd0, m_inr}, {31'd0, !m_busy});
      if (m_lr) begin
        active = 1'b1; clr_cyc = cyc; first = '0; hold = 0; hold_rd = 0;
      end
      rel = cyc - clr_cyc + 1;
      if (active)
        for (int i = 0; i < 6; i++)
          if (m_wr[i] && first[i] == 8'd0) first[i] = 8'(rel);
      if (m_ov && !prev_ov) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
          cur = '0;
        end else begin
          cur = q.pop_front();
          chk("latency", rel, {24'd0, cur.lat});
          chk("ovf_flag", {31'd0, m_ovf}, {31'd0, cur.ovf});
          for (int i = 0; i < 6; i++)
            chk($sformatf("wr_cycle_%0d", i), {24'd0, first[i]}, {24'd0, cur.wr[i]});
        end
      end
      if (m_ov) begin
        hold++;
        if (m_rd[5]) hold_rd++;
      end
      if (!m_ov && prev_ov) begin
        chk("out_valid_hold", hold, {24'd0, cur.hold});
        chk("rd_en_x_hold", hold_rd, {24'd0, cur.hold});
      end
      prev_ov = m_ov;
    end
  end

  task automatic push(input logic [7:0] lat, input logic ovf, input logic [5:0][7:0] wr,
                      input logic [7:0] hold);
    exp_t e;
    e.lat = lat; e.ovf = ovf; e.wr = wr; e.hold = hold;
    q.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_wr(input int idx, input string nm);
    for (int i = 0; i < 60 && !m_wr[idx]; i++) @(negedge clk);
    if (!m_wr[idx]) @(negedge clk);
    for (int i = 0; i < 60 && !m_wr[idx]; i++) @(negedge clk);
    chk(nm, {31'd0, m_wr[idx]}, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    @(negedge clk);
    for (int i = 0; i < 80 && m_busy; i++) @(negedge clk);
    chk(nm, {31'd0, m_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, m_inr}, 32'd1);
    chk("rst_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_out_valid", {31'd0, m_ov}, 32'd0);
    chk("rst_ovf", {31'd0, m_ovf}, 32'd0);
    chk("rst_enables", {20'd0, m_wr, m_rd}, 32'd0);
    chk("rst_selects", {21'd0, m_stage, m_mac, m_romw, m_map}, 32'd0);
    rst = 1'b0;

    // 1: nominal run, result taken immediately
    push(8'd12, 1'b0, WR_DEF, 8'd1);
    pulse_start();
    wait_wr(5, "t1_reach_xfer");
    chk("t1_xfer_mac", {29'd0, m_mac}, 32'd4);
    chk("t1_xfer_rd", {26'd0, m_rd}, 32'h10);
    chk("t1_xfer_romw", {29'd0, m_romw}, 32'd4);
    chk("t1_xfer_map", {29'd0, m_map}, 32'd7);
    wait_idle("t1_idle");
    chk("t1_in_ready", {31'd0, m_inr}, 32'd1);

    // 2: consumer stalls, output held 5 cycles
    out_ready = 1'b0;
    push(8'd12, 1'b0, WR_DEF, 8'd5);
    pulse_start();
    for (int i = 0; i < 60 && !m_ov; i++) @(negedge clk);
    chk("t2_reach_out", {31'd0, m_ov}, 32'd1);
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle("t2_idle");

    // 3: overflow during EXEC k=2 sticks; the next start clears it
    push(8'd12, 1'b1, WR_DEF, 8'd1);
    pulse_start();
    wait_wr(3, "t3_reach_exec2");
    chk("t3_stage_idx", {30'd0, m_stage}, 32'd2);
    ovf_in = 1'b1;
    @(posedge clk); #1 ovf_in = 1'b0;
    wait_idle("t3_idle");
    chk("t3_ovf_sticky_idle", {31'd0, m_ovf}, 32'd1);
    push(8'd12, 1'b0, WR_DEF, 8'd1);
    pulse_start();
    @(negedge clk);
    chk("t3_ovf_cleared", {31'd0, m_ovf}, 32'd0);
    wait_idle("t3b_idle");

    // 4a: start during EXEC k=1 is ignored
    push(8'd12, 1'b0, WR_DEF, 8'd1);
    pulse_start();
    wait_wr(2, "t4_reach_exec1");
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("t4_idle");
    repeat (3) @(negedge clk);
    chk("t4_no_rerun", {31'd0, m_busy}, 32'd0);

    // 4b: abort in ROMW k=2, then a fresh run completes
    pulse_start();
    for (int i = 0; i < 60 && !(m_busy && m_stage == 2'd2 && m_wr == 6'd0); i++) @(negedge clk);
    chk("t4_reach_romw2", {31'd0, m_busy && m_stage == 2'd2 && m_wr == 6'd0}, 32'd1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t4_abort_busy", {31'd0, m_busy}, 32'd0);
    chk("t4_abort_enables", {19'd0, m_lr, m_wr, m_rd}, 32'd0);
    chk("t4_abort_in_ready", {31'd0, m_inr}, 32'd1);
    push(8'd12, 1'b0, WR_DEF, 8'd1);
    pulse_start();
    wait_idle("t4b_idle");

    // 5: asynchronous reset in XFER
    pulse_start();
    wait_wr(5, "t5_reach_xfer");
    #2 rst = 1'b1;
    #1;
    chk("t5_async_wr_x", {31'd0, m_wr[5]}, 32'd0);
    chk("t5_async_busy", {31'd0, m_busy}, 32'd0);
    chk("t5_async_in_ready", {31'd0, m_inr}, 32'd1);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("t5_in_ready", {31'd0, m_inr}, 32'd1);
    chk("t5_stage_idx", {30'd0, m_stage}, 32'd0);

    // 6: two stages, ROM_LAT 2
    sel = 1'b1;
    push(8'd10, 1'b0, WR_SH, 8'd1);
    pulse_start();
    wait_wr(5, "t6_reach_xfer");
    chk("t6_xfer_mac", {29'd0, m_mac}, 32'd2);
    chk("t6_xfer_rd", {26'd0, m_rd}, 32'h04);
    chk("t6_xfer_romw", {29'd0, m_romw}, 32'd4);
    chk("t6_xfer_map", {29'd0, m_map}, 32'd7);
    wait_idle("t6_idle");

    repeat (2) @(negedge clk);
    chk("all_outputs_seen", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
